// File: rtl/enum_code_sequencer.sv
// rtl/enum_code_sequencer.sv - four-lane enum code loader with repeat passes; optional abort via ENUM_SEQ_ABORT_EN

package seq_pkg_a;
  typedef enum logic [4:0] {
    A_FIRST  = 5'b00111,
    A_SECOND = 5'b11100
  } code_e;
endpackage

package seq_pkg_b;
  typedef enum logic [5:0] {
    B_FIRST  = 6'b000111,
    B_SECOND = 6'b111000
  } code_e;
endpackage

package seq_pkg_c;
  typedef enum logic [6:0] {
    C_FIRST  = 7'b0011100,
    C_SECOND = 7'b1100011
  } code2_e;
endpackage

module enum_code_sequencer
  import seq_pkg_c::*;
#(
  parameter int          REP_W  = 4,
  parameter int unsigned ALT_EN = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [3:0]       sel,
  input  logic [REP_W-1:0] repeat_cnt,
  input  logic             out_ready,
`ifdef ENUM_SEQ_ABORT_EN
  input  logic             abort,
`endif
  output logic             out_valid,
  output logic [1:0]       out_lane,
  output logic [7:0]       out_code,
  output logic             busy,
  output logic             done,
  output logic [4:0]       code0,
  output logic [5:0]       code1,
  output logic [6:0]       code2,
  output logic [7:0]       code3
);

  typedef enum logic [7:0] {
    D_FIRST  = 8'b01011010,
    D_SECOND = 8'b11010011
  } code3_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EMIT = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [1:0]       lane_q, lane_d;
  logic [REP_W-1:0] pass_q, pass_d;
  logic [REP_W-1:0] rep_q, rep_d;
  logic [3:0]       sel_q, sel_d;

  seq_pkg_a::code_e code0_q;
  seq_pkg_b::code_e code1_q;
  code2_e           code2_q;
  code3_e           code3_q;

  // Candidate codes for the current pass; odd passes may flip every select
  seq_pkg_a::code_e cand0;
  seq_pkg_b::code_e cand1;
  code2_e           cand2;
  code3_e           cand3;
  logic [3:0]       eff_sel;
  logic             alt_flip;
  logic             hs;
  logic             last_pass;

  assign alt_flip  = (ALT_EN != 0) && pass_q[0];
  assign eff_sel   = sel_q ^ {4{alt_flip}};
  assign hs        = (state_q == S_EMIT) && out_ready;
  assign last_pass = !(pass_q < rep_q);

  // Decode per-lane candidate codes from the effective selects
  always_comb begin
    cand0 = eff_sel[0] ? seq_pkg_a::A_SECOND : seq_pkg_a::A_FIRST;
    cand1 = eff_sel[1] ? seq_pkg_b::B_SECOND : seq_pkg_b::B_FIRST;
    cand2 = eff_sel[2] ? C_SECOND : C_FIRST;
    cand3 = eff_sel[3] ? D_SECOND : D_FIRST;
  end

  // State register plus captured sequence parameters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      lane_q  <= 2'd0;
      pass_q  <= '0;
      rep_q   <= '0;
      sel_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      lane_q  <= lane_d;
      pass_q  <= pass_d;
      rep_q   <= rep_d;
      sel_q   <= sel_d;
    end
  end

  // Next-state logic: walk lanes 0..3, repeat passes, then a single DONE cycle
  always_comb begin
    state_d = state_q;
    lane_d  = lane_q;
    pass_d  = pass_q;
    rep_d   = rep_q;
    sel_d   = sel_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          sel_d   = sel;
          rep_d   = repeat_cnt;
          pass_d  = '0;
          lane_d  = 2'd0;
          state_d = S_EMIT;
        end
      end
      S_EMIT: begin
        if (hs) begin
          if (lane_q != 2'd3) begin
            lane_d = lane_q + 2'd1;
          end else if (!last_pass) begin
            pass_d = pass_q + {{(REP_W-1){1'b0}}, 1'b1};
            lane_d = 2'd0;
          end else begin
            lane_d  = 2'd0;
            state_d = S_DONE;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
`ifdef ENUM_SEQ_ABORT_EN
    if (abort && (state_q != S_IDLE)) begin
      state_d = S_IDLE;
      lane_d  = 2'd0;
    end
`endif
  end

  // Lane registers load only on their own handshake; abort does not block it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      code0_q <= seq_pkg_a::A_FIRST;
      code1_q <= seq_pkg_b::B_FIRST;
      code2_q <= C_FIRST;
      code3_q <= D_FIRST;
    end else if (hs) begin
      case (lane_q)
        2'd0: code0_q <= cand0;
        2'd1: code1_q <= cand1;
        2'd2: code2_q <= cand2;
        2'd3: code3_q <= cand3;
      endcase
    end
  end

  // Outputs derive from registered state only, so they hold while stalled
  always_comb begin
    out_valid = 1'b0;
    out_lane  = 2'd0;
    out_code  = 8'd0;
    busy      = (state_q != S_IDLE);
    done      = (state_q == S_DONE);
    if (state_q == S_EMIT) begin
      out_valid = 1'b1;
      out_lane  = lane_q;
      case (lane_q)
        2'd0: out_code = {3'b000, cand0};
        2'd1: out_code = {2'b00, cand1};
        2'd2: out_code = {1'b0, cand2};
        2'd3: out_code = cand3;
      endcase
    end
  end

  assign code0 = code0_q;
  assign code1 = code1_q;
  assign code2 = code2_q;
  assign code3 = code3_q;

endmodule

// File: tb/tb_enum_code_sequencer.sv
// tb/tb_enum_code_sequencer.sv - scoreboard bench for enum_code_sequencer

module tb_enum_code_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [3:0] sel;
  logic [3:0] repeat_cnt;
  logic       out_ready;
`ifdef ENUM_SEQ_ABORT_EN
  logic       abort;
`endif
  logic       out_valid;
  logic [1:0] out_lane;
  logic [7:0] out_code;
  logic       busy;
  logic       done;
  logic [4:0] code0;
  logic [5:0] code1;
  logic [6:0] code2;
  logic [7:0] code3;

  enum_code_sequencer #(.REP_W(4), .ALT_EN(1)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .sel        (sel),
    .repeat_cnt (repeat_cnt),
    .out_ready  (out_ready),
`ifdef ENUM_SEQ_ABORT_EN
    .abort      (abort),
`endif
    .out_valid  (out_valid),
    .out_lane   (out_lane),
    .out_code   (out_code),
    .busy       (busy),
    .done       (done),
    .code0      (code0),
    .code1      (code1),
    .code2      (code2),
    .code3      (code3)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [9:0] sb_q[$];
  logic [7:0] exp_r[4];
  bit         stalled = 0;
  logic [1:0] prev_lane;
  logic [7:0] prev_code;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] ref_code(input int lane, input logic b);
    case (lane)
      0:       return b ? 8'h1C : 8'h07;
      1:       return b ? 8'h38 : 8'h07;
      2:       return b ? 8'h63 : 8'h1C;
      default: return b ? 8'hD3 : 8'h5A;
    endcase
  endfunction

  task automatic push_seq(input logic [3:0] s, input logic [3:0] r);
    for (int p = 0; p <= int'(r); p++) begin
      for (int k = 0; k < 4; k++) begin
        logic b;
        logic [1:0] kl;
        b  = s[k] ^ p[0];
        kl = k[1:0];
        sb_q.push_back({kl, ref_code(k, b)});
      end
    end
  endtask

  // Handshake monitor: scoreboard pop, lane register model, stall stability
  always @(negedge clk) begin
    if (!rst_n) begin
      sb_q.delete();
      exp_r[0] = 8'h07; exp_r[1] = 8'h07; exp_r[2] = 8'h1C; exp_r[3] = 8'h5A;
      stalled = 0;
      check("rst_valid", out_valid, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
    end else begin
      check("reg_code0", code0, exp_r[0]);
      check("reg_code1", code1, exp_r[1]);
      check("reg_code2", code2, exp_r[2]);
      check("reg_code3", code3, exp_r[3]);
      if (stalled && out_valid) begin
        check("stall_lane", out_lane, prev_lane);
        check("stall_code", out_code, prev_code);
      end
      stalled   = out_valid && !out_ready;
      prev_lane = out_lane;
      prev_code = out_code;
      if (out_valid && out_ready) begin
        check("sb_underflow", sb_q.size() == 0, 0);
        if (sb_q.size() != 0) begin
          logic [9:0] e;
          e = sb_q.pop_front();
          check("hs_lane", out_lane, e[9:8]);
          check("hs_code", out_code, e[7:0]);
          exp_r[out_lane] = out_code;
        end
      end
    end
  end

  task automatic start_seq(input logic [3:0] s, input logic [3:0] r);
    @(posedge clk); #1;
    start = 1; sel = s; repeat_cnt = r;
    push_seq(s, r);
    @(posedge clk); #1;
    start = 0;
    check("lat_valid", out_valid, 1);
    check("lat_busy", busy, 1);
    check("lat_lane", out_lane, 0);
  endtask

  task automatic wait_done(input int stall_lane, input int stall_n, input bit poke,
                           input bit chain, input logic [3:0] csel, input logic [3:0] crep);
    int n = 0;
    int stalls = 0;
    bit got = 0;
    while (!got && n < 400) begin
      @(posedge clk); #1;
      start = poke && (n == 2);
      if (out_valid && int'(out_lane) == stall_lane && stalls < stall_n) begin
        out_ready = 0;
        stalls++;
      end else begin
        out_ready = 1;
      end
      @(negedge clk);
      if (done) got = 1;
      n++;
    end
    out_ready = 1;
    check("done_seen", got, 1);
    check("sb_drained", sb_q.size(), 0);
    check("busy_in_done", busy, 1);
    if (chain) begin
      start = 1; sel = csel; repeat_cnt = crep;
      push_seq(csel, crep);
      @(posedge clk); #1;
      check("after_done_valid", out_valid, 0);
      check("after_done_busy", busy, 0);
      check("after_done_done", done, 0);
      @(posedge clk); #1;
      start = 0;
      check("chain_valid", out_valid, 1);
      check("chain_lane", out_lane, 0);
    end else begin
      @(posedge clk); #1;
      check("done_pulse", done, 0);
      check("idle_busy", busy, 0);
    end
  endtask

  initial begin
    rst_n = 0; start = 0; sel = 0; repeat_cnt = 0; out_ready = 1;
`ifdef ENUM_SEQ_ABORT_EN
    abort = 0;
`endif
    repeat (3) @(negedge clk);
    check("rst_code0", code0, 5'h07);
    check("rst_code1", code1, 6'h07);
    check("rst_code2", code2, 7'h1C);
    check("rst_code3", code3, 8'h5A);
    check("rst_lane", out_lane, 0);
    check("rst_code", out_code, 0);
    @(posedge clk); #1;
    rst_n = 1;

    // single pass, mixed selects
    start_seq(4'b1010, 4'd0);
    wait_done(-1, 0, 0, 0, 4'd0, 4'd0);
    check("a_code1", code1, 6'h38);
    check("a_code3", code3, 8'hD3);

    // two passes, odd pass inverted
    start_seq(4'b0000, 4'd1);
    wait_done(-1, 0, 0, 0, 4'd0, 4'd0);
    check("b_code2", code2, 7'h63);

    // backpressure on lane2 plus start pulse while busy
    start_seq(4'b0100, 4'd0);
    wait_done(2, 3, 1, 0, 4'd0, 4'd0);
    repeat (3) begin
      @(negedge clk);
      check("no_queued_valid", out_valid, 0);
      check("no_queued_busy", busy, 0);
    end

    // start held through DONE: ignored in DONE, accepted the cycle after
    start_seq(4'b1111, 4'd0);
    wait_done(-1, 0, 0, 1, 4'b0011, 4'd2);
    wait_done(1, 2, 0, 0, 4'd0, 4'd0);

    // reset after lane1 handshake
    start_seq(4'b1111, 4'd2);
    begin
      int n = 0;
      bit seen = 0;
      while (!seen && n < 50) begin
        @(negedge clk);
        if (out_valid && out_ready && out_lane == 2'd1) seen = 1;
        n++;
      end
      check("lane1_seen", seen, 1);
    end
    @(posedge clk); #1;
    check("pre_rst_code1", code1, 6'h38);
    rst_n = 0;
    #1;
    check("mid_rst_busy", busy, 0);
    check("mid_rst_valid", out_valid, 0);
    check("mid_rst_code0", code0, 5'h07);
    check("mid_rst_code1", code1, 6'h07);
    repeat (2) @(negedge clk);
    @(posedge clk); #1;
    rst_n = 1;

`ifdef ENUM_SEQ_ABORT_EN
    // abort while lane2 is stalled
    start_seq(4'b1111, 4'd0);
    begin
      int n = 0;
      bit hit = 0;
      while (!hit && n < 50) begin
        @(posedge clk); #1;
        if (out_valid && out_lane == 2'd2) begin
          out_ready = 0;
          abort = 1;
          hit = 1;
        end
        n++;
      end
      check("abort_hit", hit, 1);
    end
    @(posedge clk); #1;
    abort = 0;
    out_ready = 1;
    sb_q.delete();
    check("abort_valid", out_valid, 0);
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_code0", code0, 5'h1C);
    check("abort_code1", code1, 6'h38);
    check("abort_code2", code2, 7'h1C);
    check("abort_code3", code3, 8'h5A);
    repeat (3) begin
      @(negedge clk);
      check("abort_no_done", done, 0);
    end
`endif

    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
